// File: rtl/muestra_frame_capture_pkg.sv
// Shared definitions for the frame capture stage: default frame geometry
// (must match the Sumatoria input width) and the capture FSM encoding.
package muestra_frame_capture_pkg;

  localparam int SAMPLES_DEF = 128;
  localparam int OSF_DEF     = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_HOLD    = 2'd2
  } cap_state_t;

endpackage

// File: rtl/muestra_frame_capture_thermo_check.sv
// Combinational thermometer-code validator: a word is valid when its ones
// form a contiguous run starting at bit 0 (including all-zero and all-one).
module muestra_frame_capture_thermo_check
  import muestra_frame_capture_pkg::*;
#(
  parameter int OSF = OSF_DEF
) (
  input  logic [OSF-1:0] word,
  output logic           valid
);

  logic [OSF-1:0] ok;

  assign ok[0] = 1'b1;

  // A set bit is only legal when the bit below it is also set.
  for (genvar gi = 1; gi < OSF; gi++) begin : g_bit
    assign ok[gi] = ~word[gi] | word[gi-1];
  end

  assign valid = &ok;

endmodule

// File: rtl/muestra_frame_capture.sv
// Collects OSF-bit oversampled words into a SAMPLES*OSF frame and presents it
// with a valid/ready handshake, holding it stable until accepted.
module muestra_frame_capture
  import muestra_frame_capture_pkg::*;
#(
  parameter int SAMPLES    = SAMPLES_DEF,
  parameter int OSF        = OSF_DEF,
  parameter int CONTINUOUS = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   stop,
  input  logic                   in_valid,
  input  logic [OSF-1:0]         in_data,
  input  logic                   frame_ready,
  output logic                   frame_valid,
  output logic [SAMPLES*OSF-1:0] frame_data,
  output logic                   busy,
  output logic                   bad_code,
  output logic                   overrun
);

  localparam int            CW   = $clog2(SAMPLES);
  localparam logic [CW-1:0] LAST = CW'(SAMPLES - 1);

  cap_state_t             state_reg, state_next;
  logic [CW-1:0]          cnt_reg;
  logic [SAMPLES*OSF-1:0] cap_buf_reg;
  logic [SAMPLES*OSF-1:0] cap_buf_next;
  logic                   word_ok;
  logic                   wr, last_word, can_load, load, drop, transfer, start_ok;

  muestra_frame_capture_thermo_check #(.OSF(OSF)) u_thermo_check (
    .word  (in_data),
    .valid (word_ok)
  );

  // stop dominates everything, including a word arriving in the same cycle
  assign wr        = (state_reg == ST_CAPTURE) && !stop && in_valid;
  assign last_word = wr && (cnt_reg == LAST);
  assign transfer  = frame_valid && frame_ready;
  assign can_load  = !frame_valid || frame_ready;
  assign load      = last_word && can_load;
  assign drop      = last_word && !can_load;
  assign start_ok  = start && !stop && (state_reg == ST_IDLE);

  // Next-buffer view already contains the incoming word, so a completing
  // frame can be copied out in the same cycle as its final word.
  for (genvar gi = 0; gi < SAMPLES; gi++) begin : g_slot
    assign cap_buf_next[gi*OSF +: OSF] =
      (wr && (cnt_reg == CW'(gi))) ? in_data : cap_buf_reg[gi*OSF +: OSF];
  end

  always_comb begin
    state_next = state_reg;
    if (stop) begin
      state_next = ST_IDLE;
    end else begin
      case (state_reg)
        ST_IDLE:    if (start) state_next = ST_CAPTURE;
        ST_CAPTURE: if (last_word && (CONTINUOUS == 0)) state_next = ST_HOLD;
        ST_HOLD:    if (transfer) state_next = ST_IDLE;
        default:    state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= ST_IDLE;
      cnt_reg     <= '0;
      cap_buf_reg <= '0;
      frame_data  <= '0;
      frame_valid <= 1'b0;
      bad_code    <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cap_buf_reg <= cap_buf_next;

      if (stop || start_ok) cnt_reg <= '0;
      else if (wr)          cnt_reg <= cnt_reg + CW'(1);

      if (load) begin
        frame_data  <= cap_buf_next;
        frame_valid <= 1'b1;
      end else if (transfer) begin
        frame_valid <= 1'b0;
      end

      // Sticky flags: a new event in the start cycle takes priority over clear
      if (wr && !word_ok) bad_code <= 1'b1;
      else if (start_ok)  bad_code <= 1'b0;

      if (drop)          overrun <= 1'b1;
      else if (start_ok) overrun <= 1'b0;
    end
  end

  assign busy = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_muestra_frame_capture.sv
// Directed bench for the frame capture stage: table-driven single frames plus
// hand-written continuous, stop, async-reset and full-size frame sequences.
module tb_muestra_frame_capture;

  logic clk = 1'b0;
  logic rst_n, start, stop, in_valid, frame_ready;
  logic [7:0] in_data;

  logic        fv, busy, bad, ovr;
  logic [31:0] fd;
  logic        fv_c, busy_c, bad_c, ovr_c;
  logic [31:0] fd_c;
  logic        fv_b, busy_b, bad_b, ovr_b;
  logic [1023:0] fd_b;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  muestra_frame_capture #(.SAMPLES(4), .OSF(8), .CONTINUOUS(0)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .in_valid(in_valid),
    .in_data(in_data), .frame_ready(frame_ready), .frame_valid(fv),
    .frame_data(fd), .busy(busy), .bad_code(bad), .overrun(ovr)
  );

  muestra_frame_capture #(.SAMPLES(4), .OSF(8), .CONTINUOUS(1)) dut_c (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .in_valid(in_valid),
    .in_data(in_data), .frame_ready(frame_ready), .frame_valid(fv_c),
    .frame_data(fd_c), .busy(busy_c), .bad_code(bad_c), .overrun(ovr_c)
  );

  muestra_frame_capture dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .in_valid(in_valid),
    .in_data(in_data), .frame_ready(frame_ready), .frame_valid(fv_b),
    .frame_data(fd_b), .busy(busy_b), .bad_code(bad_b), .overrun(ovr_b)
  );

  typedef struct {
    logic [3:0][7:0] w;
    logic [31:0]     exp_data;
    logic            exp_bad;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] w);
    in_valid = 1'b1;
    in_data  = w;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    tick();
  endtask

  function automatic int popcount(input logic [1023:0] v);
    int s = 0;
    for (int i = 0; i < 1024; i++) s += int'(v[i]);
    return s;
  endfunction

  initial begin
    logic [1023:0] exp_b;
    logic [8:0]    t;
    logic [7:0]    w;
    int            n, sum;

    vecs[0] = '{w: {8'hFF, 8'h0F, 8'h03, 8'h01}, exp_data: 32'hFF0F0301, exp_bad: 1'b0};
    vecs[1] = '{w: {8'hFF, 8'h07, 8'h05, 8'h00}, exp_data: 32'hFF070500, exp_bad: 1'b1};
    vecs[2] = '{w: {8'h00, 8'h1F, 8'h3F, 8'h7F}, exp_data: 32'h001F3F7F, exp_bad: 1'b0};
    vecs[3] = '{w: {8'h01, 8'h01, 8'hFE, 8'h80}, exp_data: 32'h0101FE80, exp_bad: 1'b1};
    vecs[4] = '{w: {8'h00, 8'h00, 8'h00, 8'h00}, exp_data: 32'h00000000, exp_bad: 1'b0};

    rst_n = 1'b0; start = 1'b0; stop = 1'b0; in_valid = 1'b0;
    in_data = 8'h00; frame_ready = 1'b0;
    tick();
    check("reset frame_valid", 64'(fv), 64'd0);
    check("reset frame_data", 64'(fd), 64'd0);
    check("reset busy", 64'(busy), 64'd0);
    check("reset bad_code", 64'(bad), 64'd0);
    check("reset overrun", 64'(ovr), 64'd0);
    rst_n = 1'b1;
    tick();

    // Words in IDLE must be ignored entirely
    send(8'h05);
    check("idle ignores bad word", 64'(bad), 64'd0);
    check("idle busy", 64'(busy), 64'd0);

    for (int v = 0; v < 5; v++) begin
      pulse_start();
      check("start clears bad_code", 64'(bad), 64'd0);
      check("busy after start", 64'(busy), 64'd1);
      for (int k = 0; k < 4; k++) begin
        if (k == 3) check("no frame before last word", 64'(fv), 64'd0);
        send(vecs[v].w[k]);
      end
      $display("vec %0d: frame_valid=%b frame_data=%h bad_code=%b", v, fv, fd, bad);
      check("frame_valid latency", 64'(fv), 64'd1);
      check("frame_data", 64'(fd), 64'(vecs[v].exp_data));
      check("bad_code", 64'(bad), 64'(vecs[v].exp_bad));
      send(8'h55);
      tick();
      check("hold frame_valid", 64'(fv), 64'd1);
      check("hold frame_data", 64'(fd), 64'(vecs[v].exp_data));
      check("hold bad_code", 64'(bad), 64'(vecs[v].exp_bad));
      frame_ready = 1'b1;
      tick();
      frame_ready = 1'b0;
      check("accept frame_valid", 64'(fv), 64'd0);
      check("accept busy", 64'(busy), 64'd0);
    end

    // Continuous mode: drop, then load coinciding with a transfer
    do_reset();
    pulse_start();
    send(8'h01); send(8'h03); send(8'h07); send(8'h0F);
    $display("cont frame A: frame_valid=%b frame_data=%h overrun=%b", fv_c, fd_c, ovr_c);
    check("cont A valid", 64'(fv_c), 64'd1);
    check("cont A data", 64'(fd_c), 64'h0F070301);
    check("cont A overrun", 64'(ovr_c), 64'd0);
    send(8'hFF); send(8'hFF); send(8'hFF); send(8'hFF);
    $display("cont frame B: frame_valid=%b frame_data=%h overrun=%b", fv_c, fd_c, ovr_c);
    check("cont B overrun", 64'(ovr_c), 64'd1);
    check("cont B data kept", 64'(fd_c), 64'h0F070301);
    check("cont B valid", 64'(fv_c), 64'd1);
    send(8'h00); send(8'h01); send(8'h00);
    frame_ready = 1'b1;
    send(8'h01);
    frame_ready = 1'b0;
    $display("cont frame C: frame_valid=%b frame_data=%h busy=%b", fv_c, fd_c, busy_c);
    check("cont C valid stays", 64'(fv_c), 64'd1);
    check("cont C data", 64'(fd_c), 64'h01000100);
    check("cont C busy", 64'(busy_c), 64'd1);
    frame_ready = 1'b1;
    tick();
    frame_ready = 1'b0;
    check("cont C accepted", 64'(fv_c), 64'd0);
    pulse_stop();
    check("cont stop busy", 64'(busy_c), 64'd0);

    // Stop mid-frame discards the partial frame
    do_reset();
    pulse_start();
    send(8'hFF); send(8'hFF);
    pulse_stop();
    check("stop busy", 64'(busy), 64'd0);
    pulse_start();
    send(8'h0F); send(8'h07); send(8'h03); send(8'h01);
    $display("after stop: frame_valid=%b frame_data=%h", fv, fd);
    check("after stop valid", 64'(fv), 64'd1);
    check("after stop data", 64'(fd), 64'h0103070F);

    // Asynchronous reset while a frame is pending
    #2;
    rst_n = 1'b0;
    #1;
    $display("async reset: frame_valid=%b frame_data=%h busy=%b", fv, fd, busy);
    check("async rst frame_valid", 64'(fv), 64'd0);
    check("async rst frame_data", 64'(fd), 64'd0);
    check("async rst busy", 64'(busy), 64'd0);
    rst_n = 1'b1;
    tick();

    // Full-size frame with random thermometer words
    do_reset();
    pulse_start();
    exp_b = '0;
    sum   = 0;
    for (int k = 0; k < 128; k++) begin
      n = $urandom_range(0, 8);
      t = (9'd1 << n) - 9'd1;
      w = t[7:0];
      exp_b[k*8 +: 8] = w;
      sum += n;
      if (k == 127) begin
        checks++;
        if (fv_b !== 1'b0) begin
          errors++;
          $display("FAIL big early valid: got %b expected 0", fv_b);
        end
      end
      send(w);
    end
    $display("big frame: frame_valid=%b sum=%0d bad_code=%b", fv_b, popcount(fd_b), bad_b);
    check("big valid", 64'(fv_b), 64'd1);
    check("big popcount", 64'(popcount(fd_b)), 64'(sum));
    check("big bad_code", 64'(bad_b), 64'd0);
    checks++;
    if (fd_b !== exp_b) begin
      errors++;
      $display("FAIL big frame_data: got %h expected %h", fd_b[127:0], exp_b[127:0]);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
